fnd_scan_rx: RTL
================

Name: fnd_scan_rx

Overview:
- Receive-side monitor for the multiplexed 6-digit 7-segment bus (segments, dp, active-low digit enables) that the display driver scans out.
- Samples the bus, captures each digit once it has settled, and reassembles complete frames.
- Decodes segments back to BCD and HH:MM:SS values, and flags protocol errors.
- Used for display loopback self-check and as a bench scoreboard front end.

Parameters:
- SETTLE_CYC, 4: enable and segments must be unchanged this many clk cycles before a digit is captured.
- TIMEOUT_CYC, 100000: clk cycles without a new digit capture before o_stale asserts.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- i_seg  input  7  segments {a..g}, active-high.
- i_seg_dp  input  1  decimal point.
- i_seg_enb  input  6  digit enables, active-low one-hot; bit0 = rightmost digit (seconds units).
- o_six_digit_seg  output  42  raw captured segments; digit k at [7k+6:7k].
- o_six_bcd  output  24  decoded digits; digit k at [4k+3:4k].
- o_six_dp  output  6  captured dp per digit.
- o_sec, o_min, o_hou  output  6 each  binary values: digit1*10+digit0, digit3*10+digit2, digit5*10+digit4.
- o_bad_mask  output  6  digit k of the last frame had an undecodable pattern.
- o_frame_valid  output  1  one-cycle pulse when a full frame commits.
- o_err  output  1  one-cycle pulse on a protocol error.
- o_stale  output  1  level; bus not scanning.

Behaviour:
- Reset: all outputs 0, internal shadow registers 0, FSM in HUNT, timeout counter 0.
- Input sampling: all 14 inputs pass through a 2-flop synchronizer. All timing below refers to the synchronized bus.
- Settle filter:
  - A counter clears whenever {enb, seg, dp} differs from the previous cycle; otherwise it increments, saturating at SETTLE_CYC.
  - A capture strobe fires on the cycle the counter reaches SETTLE_CYC. This gives exactly one strobe per stable phase.
- Enable classification at the strobe:
  - Exactly one bit low gives digit index k.
  - All ones is a blank gap: no capture, no error.
  - More than one bit low is a multi-enable error.
- FSM:
  - HUNT: waits for a strobe with k=0. It captures digit 0 into shadow slot 0, sets expect=1, and goes to COLLECT.
  - COLLECT, strobe with k==expect: write shadow slot k, expect+=1.
  - COLLECT, strobe with k==5: after the write, commit and return to COLLECT with expect=0.
  - COLLECT, strobe with k!=expect, or a multi-enable: pulse o_err, discard the shadow, go to HUNT. A k=0 strobe in this case is not reused as a restart.
  - COLLECT with expect=0: a k=0 strobe is accepted normally, so back-to-back frames are continuous.
- Commit (one cycle after the k=5 strobe):
  - Copy the shadow to o_six_digit_seg and o_six_dp.
  - Copy decoded values to o_six_bcd, o_bad_mask, o_sec, o_min and o_hou.
  - Pulse o_frame_valid in that same cycle.
  - Outputs hold between commits.
- Segment decode (pure function):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 73→9.
  - 00→4'hE (blank, not bad).
  - Any other pattern→4'hF and sets the bad bit.
- Value math:
  - tens*10+units computed in 7 bits, output truncated to 6 bits.
  - If either digit is ≥4'hA, the field output is 6'd63.
- Timeout:
  - The counter clears on every capture strobe and otherwise increments, saturating.
  - o_stale=1 while counter ≥ TIMEOUT_CYC.
  - o_stale clears on the next strobe. The FSM drops to HUNT when o_stale rises.
- Simultaneous events: a strobe on the same cycle as the timeout threshold counts as a strobe, so o_stale stays 0.
- Reset mid-frame: shadow discarded, outputs cleared immediately.

Decomposition:
- Package fnd_scan_pkg holds:
  - FSM state encoding (HUNT, COLLECT).
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - BCD codes BCD_BLANK=4'hE and BCD_BAD=4'hF.
  - Digit count NUM_DIGITS=6.
- One sub-module: fnd_enc_dec, the combinational segment→BCD decoder, instantiated six times on the committed shadow.

Test Plan:
- Nominal scan: drive the display driver's order (enb 111110…011111, 5000 cycles per digit) showing 12:34:56 → after the digit-5 phase, one o_frame_valid pulse, o_hou=12, o_min=34, o_sec=56, o_six_bcd=24'h123456, o_bad_mask=0.
- Out of order: digits 0,1,3 → o_err pulse at the digit-3 strobe, no frame_valid. Next full 0..5 scan commits normally.
- Glitch/settle: toggle i_seg every 2 cycles during a digit phase, then hold → a single capture holding the final stable pattern. A phase shorter than SETTLE_CYC is never captured.
- Bad pattern: digit 2 = 7'h01 → o_bad_mask=6'b000100, bcd digit2=F, o_min=63, frame_valid still pulses.
- Multi-enable and blank: enb=111100 → o_err pulse. enb=111111 between digits → no error, frame still commits.
- Stale and reset: freeze the bus for TIMEOUT_CYC → o_stale=1, FSM in HUNT. Resume → o_stale=0 at the first strobe. Assert rst_n mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/fnd_scan_pkg.sv
// Shared definitions for the 7-segment scan receiver: FSM states, segment
// patterns, special BCD codes and the two-digit field arithmetic.
package fnd_scan_pkg;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hE;
  localparam logic [3:0] BCD_BAD   = 4'hF;

  // Any non-numeric digit (blank or bad) marks the whole field as 63.
  function automatic logic [5:0] field_value(input logic [3:0] tens, input logic [3:0] units);
    logic [6:0] sum;
    sum = 7'(tens) * 7'd10 + 7'(units);
    if ((tens >= 4'hA) || (units >= 4'hA)) begin
      return 6'd63;
    end
    return 6'(sum);
  endfunction

endpackage

// File: rtl/fnd_enc_dec.sv
// Combinational 7-segment to BCD decoder; blank decodes to BCD_BLANK,
// anything unrecognised decodes to BCD_BAD and raises bad_o.
module fnd_enc_dec
  import fnd_scan_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       bad_o
);

  always_comb begin
    bcd_o = BCD_BAD;
    bad_o = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: bcd_o = BCD_BLANK;
      default:   bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Receive-side monitor for a multiplexed 6-digit 7-segment bus: settles each
// scanned digit, reassembles frames, decodes them and flags protocol errors.
module fnd_scan_rx
  import fnd_scan_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [41:0] o_six_digit_seg,
  output logic [23:0] o_six_bcd,
  output logic [5:0]  o_six_dp,
  output logic [5:0]  o_sec,
  output logic [5:0]  o_min,
  output logic [5:0]  o_hou,
  output logic [5:0]  o_bad_mask,
  output logic        o_frame_valid,
  output logic        o_err,
  output logic        o_stale
);

  localparam int BUS_W = 14;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_MAX  = SET_W'(SETTLE_CYC);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYC);

  logic [BUS_W-1:0] sync1_q, sync2_q, prev_q;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic             bus_changed, strobe, stale_rise;

  logic [5:0] enb_low;
  logic [6:0] bus_seg;
  logic       bus_dp;
  logic [2:0] low_cnt, dig_idx;
  logic       one_low, multi_low;

  state_e                     state_q, state_d;
  logic [2:0]                 want_q, want_d;
  logic [NUM_DIGITS-1:0][6:0] shadow_seg_q, shadow_seg_d;
  logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
  logic                       commit_q, commit_d;
  logic                       err_q, err_d;

  logic [23:0] dec_bcd;
  logic [5:0]  dec_bad;

  logic [41:0] seg_out_q;
  logic [23:0] bcd_out_q;
  logic [5:0]  dp_out_q, bad_out_q, sec_q, min_q, hou_q;
  logic        frame_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {i_seg_enb, i_seg, i_seg_dp};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Settle filter: the strobe fires once, on the step into SETTLE_MAX.
  assign bus_changed = (sync2_q != prev_q);
  assign strobe      = !bus_changed && (settle_q == SETTLE_LAST);

  always_comb begin
    settle_d = settle_q;
    if (bus_changed) begin
      settle_d = '0;
    end else if (settle_q != SETTLE_MAX) begin
      settle_d = settle_q + SET_W'(1);
    end
  end

  assign enb_low = ~sync2_q[13:8];
  assign bus_seg = sync2_q[7:1];
  assign bus_dp  = sync2_q[0];

  always_comb begin
    low_cnt = 3'd0;
    dig_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (enb_low[i]) begin
        low_cnt = low_cnt + 3'd1;
        dig_idx = 3'(i);
      end
    end
  end

  assign one_low   = (low_cnt == 3'd1);
  assign multi_low = (low_cnt > 3'd1);

  always_comb begin
    idle_d = idle_q;
    if (strobe) begin
      idle_d = '0;
    end else if (idle_q != TO_MAX) begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  assign stale_rise = (idle_d == TO_MAX) && (idle_q != TO_MAX);
  assign o_stale    = (idle_q >= TO_MAX);

  always_comb begin
    state_d      = state_q;
    want_d       = want_q;
    shadow_seg_d = shadow_seg_q;
    shadow_dp_d  = shadow_dp_q;
    commit_d     = 1'b0;
    err_d        = 1'b0;
    if (stale_rise) begin
      state_d = HUNT;
      want_d  = 3'd0;
    end else if (strobe && (one_low || multi_low)) begin
      case (state_q)
        HUNT: begin
          if (one_low && (dig_idx == 3'd0)) begin
            shadow_seg_d[0] = bus_seg;
            shadow_dp_d[0]  = bus_dp;
            want_d          = 3'd1;
            state_d         = COLLECT;
          end
        end
        COLLECT: begin
          if (one_low && (dig_idx == want_q)) begin
            shadow_seg_d[dig_idx] = bus_seg;
            shadow_dp_d[dig_idx]  = bus_dp;
            if (dig_idx == 3'(NUM_DIGITS - 1)) begin
              want_d   = 3'd0;
              commit_d = 1'b1;
            end else begin
              want_d = want_q + 3'd1;
            end
          end else begin
            // The offending strobe is dropped, even a k=0 one; HUNT waits for the next.
            err_d        = 1'b1;
            state_d      = HUNT;
            want_d       = 3'd0;
            shadow_seg_d = '0;
            shadow_dp_d  = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q     <= '0;
      idle_q       <= '0;
      state_q      <= HUNT;
      want_q       <= 3'd0;
      shadow_seg_q <= '0;
      shadow_dp_q  <= '0;
      commit_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      idle_q       <= idle_d;
      state_q      <= state_d;
      want_q       <= want_d;
      shadow_seg_q <= shadow_seg_d;
      shadow_dp_q  <= shadow_dp_d;
      commit_q     <= commit_d;
      err_q        <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    fnd_enc_dec u_dec (
      .seg_i (shadow_seg_q[g]),
      .bcd_o (dec_bcd[4*g +: 4]),
      .bad_o (dec_bad[g])
    );
  end

  // Commit: the shadow is complete one cycle after the digit-5 strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out_q     <= '0;
      bcd_out_q     <= '0;
      dp_out_q      <= '0;
      bad_out_q     <= '0;
      sec_q         <= '0;
      min_q         <= '0;
      hou_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= commit_q;
      if (commit_q) begin
        seg_out_q <= shadow_seg_q;
        dp_out_q  <= shadow_dp_q;
        bcd_out_q <= dec_bcd;
        bad_out_q <= dec_bad;
        sec_q     <= field_value(dec_bcd[7:4], dec_bcd[3:0]);
        min_q     <= field_value(dec_bcd[15:12], dec_bcd[11:8]);
        hou_q     <= field_value(dec_bcd[23:20], dec_bcd[19:16]);
      end
    end
  end

  assign o_six_digit_seg = seg_out_q;
  assign o_six_bcd       = bcd_out_q;
  assign o_six_dp        = dp_out_q;
  assign o_bad_mask      = bad_out_q;
  assign o_sec           = sec_q;
  assign o_min           = min_q;
  assign o_hou           = hou_q;
  assign o_frame_valid   = frame_valid_q;
  assign o_err           = err_q;

endmodule
